// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/I-O responder: FSM encoding, default widths
// and the memory-mapped I/O word address the datapath also decodes.
package mem_io_responder_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_ADDR_W = 16;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_io_responder_if.sv
// Request/response bus between the datapath memory port (master) and the
// responder (slave).
interface mem_io_responder_if
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_io_responder_io_port_component.sv
// Memory-mapped I/O word: registers the board input every cycle and holds the
// board output, pulsing a strobe the cycle after each update.
module io_port_component #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] read_in,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] io_in_o,
    output logic [DATA_W-1:0] write_out,
    output logic              write_out_strobe
);

    logic [DATA_W-1:0] ioIn_q;
    logic [DATA_W-1:0] writeOut_q;
    logic              strobe_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            ioIn_q     <= '0;
            writeOut_q <= '0;
            strobe_q   <= 1'b0;
        end else begin
            ioIn_q   <= read_in;
            strobe_q <= wr_en_i;
            if (wr_en_i) begin
                writeOut_q <= wr_data_i;
            end
        end
    end

    assign io_in_o          = ioIn_q;
    assign write_out        = writeOut_q;
    assign write_out_strobe = strobe_q;

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the processor memory port: word RAM plus one I/O word, answering
// each request with a single-cycle strobe a fixed number of cycles after acceptance.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned       DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned       ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned       DEPTH   = 256,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEFAULT),
    parameter int unsigned       LATENCY = 2
) (
    input  logic              clock,
    input  logic              rst,
    mem_io_responder_if.slave bus,
    input  logic [DATA_W-1:0] read_in,
    output logic [DATA_W-1:0] write_out,
    output logic              write_out_strobe
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              reqWrite_q,  reqWrite_d;
    logic [ADDR_W-1:0] reqAddr_q,   reqAddr_d;
    logic [DATA_W-1:0] reqWdata_q,  reqWdata_d;

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [DATA_W-1:0] ioIn;
    logic [IDX_W-1:0]  ramIdx;
    logic              isRam;
    logic              isIo;
    logic              ramWrEn;
    logic              ioWrEn;

    assign ramIdx  = reqAddr_q[IDX_W-1:0];
    assign isRam   = 32'(reqAddr_q) < DEPTH;
    assign isIo    = reqAddr_q == IO_ADDR;
    assign ramWrEn = (state_q == RESP) && reqWrite_q && isRam;
    assign ioWrEn  = (state_q == RESP) && reqWrite_q && isIo;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reqWrite_q <= 1'b0;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reqWrite_q <= reqWrite_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
        end
    end

    // Ready is gated by reset so it only rises once reset has been released.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        reqWrite_d     = reqWrite_q;
        reqAddr_d      = reqAddr_q;
        reqWdata_d     = reqWdata_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = rst;
                if (bus.req_valid) begin
                    reqWrite_d = bus.req_write;
                    reqAddr_d  = bus.req_addr;
                    reqWdata_d = bus.req_wdata;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (!isRam && !isIo) begin
                    bus.resp_err = 1'b1;
                end else if (!reqWrite_q) begin
                    bus.resp_rdata = isIo ? ioIn : ram_q[ramIdx];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (ramWrEn) begin
            ram_q[ramIdx] <= reqWdata_q;
        end
    end

    io_port_component #(
        .DATA_W(DATA_W)
    ) ioPort (
        .clock            (clock),
        .rst              (rst),
        .read_in          (read_in),
        .wr_en_i          (ioWrEn),
        .wr_data_i        (reqWdata_q),
        .io_in_o          (ioIn),
        .write_out        (write_out),
        .write_out_strobe (write_out_strobe)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized checks of mem_io_responder against a behavioural
// memory/I-O model; one instance at latency 2 and one at latency 1.
module tb_mem_io_responder;
    import mem_io_responder_pkg::*;

    localparam int          DW    = 16;
    localparam int          AW    = 16;
    localparam int          DEPTH = 256;
    localparam int          LAT_A = 2;
    localparam int          LAT_B = 1;
    localparam logic [15:0] IOA   = 16'hFFFF;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic [15:0] readInA = '0;
    logic [15:0] readInB = '0;
    logic [15:0] writeOutA, writeOutB;
    logic        strobeA, strobeB;

    int total = 0;
    int bad   = 0;

    logic [15:0] ramModel [int];
    logic [15:0] wrOutModel = '0;

    mem_io_responder_if #(.DATA_W(DW), .ADDR_W(AW)) busA ();
    mem_io_responder_if #(.DATA_W(DW), .ADDR_W(AW)) busB ();

    mem_io_responder #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .IO_ADDR(IOA), .LATENCY(LAT_A)
    ) dutA (
        .clock            (clock),
        .rst              (rst),
        .bus              (busA),
        .read_in          (readInA),
        .write_out        (writeOutA),
        .write_out_strobe (strobeA)
    );

    mem_io_responder #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .IO_ADDR(IOA), .LATENCY(LAT_B)
    ) dutB (
        .clock            (clock),
        .rst              (rst),
        .bus              (busB),
        .read_in          (readInB),
        .write_out        (writeOutB),
        .write_out_strobe (strobeB)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance A, checked against the model.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] rin);
        int          waitCnt;
        bit          isRam, isIo, known, expStrobe;
        logic [15:0] expData;
        waitCnt = 0;
        @(negedge clock);
        while (!busA.req_ready && waitCnt < 20) begin
            @(negedge clock);
            waitCnt++;
        end
        checkOutput("readyBeforeReq", 32'(busA.req_ready), 32'd1);
        busA.req_valid = 1'b1;
        busA.req_write = wr;
        busA.req_addr  = addr;
        busA.req_wdata = wdata;
        readInA        = rin;
        @(posedge clock);
        #1;
        busA.req_valid = 1'b0;
        busA.req_write = ~wr;
        busA.req_addr  = ~addr;
        busA.req_wdata = ~wdata;

        isRam   = int'(addr) < DEPTH;
        isIo    = addr == IOA;
        known   = 1'b1;
        expData = '0;
        if (!wr && isIo) begin
            expData = rin;
        end else if (!wr && isRam) begin
            if (ramModel.exists(int'(addr))) expData = ramModel[int'(addr)];
            else known = 1'b0;
        end

        waitCnt = 0;
        do begin
            @(negedge clock);
            waitCnt++;
        end while (!busA.resp_valid && waitCnt < 10);
        checkOutput("respLatency", 32'(waitCnt), 32'(LAT_A));
        checkOutput("respValid", 32'(busA.resp_valid), 32'd1);
        checkOutput("respErr", 32'(busA.resp_err), 32'(!isRam && !isIo));
        if (known) checkOutput("respRdata", 32'(busA.resp_rdata), 32'(expData));

        if (wr && isRam) ramModel[int'(addr)] = wdata;
        expStrobe = wr && isIo;
        if (expStrobe) wrOutModel = wdata;

        @(negedge clock);
        checkOutput("respValidOneCycle", 32'(busA.resp_valid), 32'd0);
        checkOutput("writeOutStrobe", 32'(strobeA), 32'(expStrobe));
        checkOutput("writeOut", 32'(writeOutA), 32'(wrOutModel));
        @(negedge clock);
        checkOutput("strobeOneCycle", 32'(strobeA), 32'd0);
        checkOutput("writeOutHeld", 32'(writeOutA), 32'(wrOutModel));
    endtask

    initial begin
        int          waitCnt;
        logic [15:0] a;

        busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_addr = '0; busA.req_wdata = '0;
        busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_addr = '0; busB.req_wdata = '0;
        readInB = 16'h0ABC;

        #12;
        checkOutput("rstRespValid", 32'(busA.resp_valid), 32'd0);
        checkOutput("rstRespRdata", 32'(busA.resp_rdata), 32'd0);
        checkOutput("rstRespErr", 32'(busA.resp_err), 32'd0);
        checkOutput("rstReadyLow", 32'(busA.req_ready), 32'd0);
        checkOutput("rstWriteOut", 32'(writeOutA), 32'd0);
        checkOutput("rstStrobe", 32'(strobeA), 32'd0);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        checkOutput("readyAfterRst", 32'(busA.req_ready), 32'd1);

        applyStimulus(1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        applyStimulus(1'b0, 16'h0010, 16'h0000, 16'h0000);
        applyStimulus(1'b1, IOA, 16'h00A5, 16'h0000);
        applyStimulus(1'b0, IOA, 16'h0000, 16'h1234);
        applyStimulus(1'b0, IOA, 16'h0000, 16'h4321);

        applyStimulus(1'b1, 16'h0000, 16'h5555, 16'h0000);
        applyStimulus(1'b0, 16'h0200, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 16'h0200, 16'h9999, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 16'h0100, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 16'h00FF, 16'h0FF0, 16'h0000);
        applyStimulus(1'b0, 16'h00FF, 16'h0000, 16'h0000);

        // Reset during WAIT drops the store.
        applyStimulus(1'b1, 16'h0005, 16'h1111, 16'h0000);
        @(negedge clock);
        busA.req_valid = 1'b1; busA.req_write = 1'b1;
        busA.req_addr = 16'h0005; busA.req_wdata = 16'h7777;
        @(posedge clock);
        #1;
        busA.req_valid = 1'b0;
        @(negedge clock);
        rst = 1'b0;
        #1;
        checkOutput("midRstRespValid", 32'(busA.resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("midRstNoResp", 32'(busA.resp_valid), 32'd0);
        end
        rst = 1'b1;
        wrOutModel = '0;
        @(negedge clock);
        checkOutput("midRstReady", 32'(busA.req_ready), 32'd1);
        checkOutput("midRstWriteOut", 32'(writeOutA), 32'd0);
        applyStimulus(1'b0, 16'h0005, 16'h0000, 16'h0000);

        // Latency-1 instance with req_valid held high: one acceptance every two cycles.
        @(negedge clock);
        busB.req_valid = 1'b1; busB.req_write = 1'b0; busB.req_addr = IOA;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("b2bReady", 32'(busB.req_ready), 32'((i % 2) == 0));
            checkOutput("b2bRespValid", 32'(busB.resp_valid), 32'((i % 2) == 1));
            if ((i % 2) == 1) checkOutput("b2bRdata", 32'(busB.resp_rdata), 32'h0ABC);
            @(negedge clock);
        end
        busB.req_valid = 1'b0;
        checkOutput("b2bNoStrobe", 32'(strobeB), 32'd0);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 16'($urandom_range(0, 15));
                5:             a = 16'($urandom_range(16, DEPTH - 1));
                6, 7:          a = IOA;
                default:       a = 16'($urandom_range(DEPTH, 16'hFFFE));
            endcase
            applyStimulus(1'($urandom_range(0, 1)), a, 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
